upsample2d_stream: RTL and testbench

UPSAMPLE2D_STREAM -- requirements
Module: upsample2d_stream

---
 rtl/upsample2d_stream.sv | 129 ++++++++++++
 tb/tb_upsample2d_stream.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/upsample2d_stream.sv
// upsample2d_stream -- 2x nearest-neighbour upsampler on a pixel stream.
//
// One input row is captured into a line buffer (FILL), then emitted twice
// (REP0, REP1) with every pixel repeated twice, so each input row becomes
// two output rows of 2*IN_W pixels. Input and output never overlap: the
// block either fills or replays.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid    input pixel stream (raster order)
//   in_ready            high in FILL (and out of reset)
//   out_data/out_valid  upsampled pixel stream (raster order)
//   out_ready           downstream accept
//   out_eol/out_eof     last pixel of output row / output frame
module upsample2d_stream #(
  parameter int IN_W      = 2,
  parameter int IN_H      = 2,
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_eol,
  output logic                 out_eof
);

  localparam int CW  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int OCW = $clog2(2 * IN_W);
  localparam int RW  = (IN_H > 1) ? $clog2(IN_H) : 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(IN_W - 1);
  localparam logic [OCW-1:0] OC_LAST  = OCW'(2 * IN_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IN_H - 1);

  typedef enum logic [1:0] {FILL, REP0, REP1} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [OCW-1:0]       ocnt_q, ocnt_d;
  logic [RW-1:0]        row_q, row_d;
  logic [BIT_WIDTH-1:0] lbuf_q [IN_W];

  logic          wr_en;
  logic          rd_en;
  logic [CW-1:0] rd_idx;

  // in_ready is gated by rst directly so it is low during reset and high
  // at the very first edge after release, without a registered delay.
  assign in_ready  = (state_q == FILL) && !rst;
  assign out_valid = (state_q == REP0) || (state_q == REP1);
  assign wr_en     = in_ready && in_valid;
  assign rd_en     = out_valid && out_ready;

  // Each buffer entry is read for two consecutive output pixels.
  assign rd_idx  = CW'(ocnt_q >> 1);
  assign out_eol = out_valid && (ocnt_q == OC_LAST);
  assign out_eof = out_eol && (state_q == REP1) && (row_q == ROW_LAST);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < IN_W; i++)
      if (rd_idx == CW'(i)) out_data = lbuf_q[i];
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    ocnt_d  = ocnt_q;
    row_d   = row_q;
    unique case (state_q)
      FILL: begin
        if (wr_en) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            ocnt_d  = '0;
            state_d = REP0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      REP0, REP1: begin
        if (rd_en) begin
          if (ocnt_q == OC_LAST) begin
            ocnt_d = '0;
            if (state_q == REP0) begin
              state_d = REP1;
            end else begin
              state_d = FILL;
              row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end
          end else begin
            ocnt_d = ocnt_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      col_q   <= '0;
      ocnt_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      ocnt_q  <= ocnt_d;
      row_q   <= row_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IN_W; i++) lbuf_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < IN_W; i++)
        if (col_q == CW'(i)) lbuf_q[i] <= in_data;
    end
  end

endmodule

// File: tb/tb_upsample2d_stream.sv
module tb_upsample2d_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_eol;
  logic       out_eof;

  upsample2d_stream #(.IN_W(2), .IN_H(2), .BIT_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_eol  (out_eol),
    .out_eof  (out_eof)
  );

  always #5 clk = ~clk;

  // {eof, eol, data}
  logic [9:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int npop  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-written expected stream for frame 10,20,30,40.
  logic [7:0] f1_data [16] = '{8'h10, 8'h10, 8'h20, 8'h20, 8'h10, 8'h10, 8'h20, 8'h20,
                               8'h30, 8'h30, 8'h40, 8'h40, 8'h30, 8'h30, 8'h40, 8'h40};

  task automatic push_f1();
    for (int k = 0; k < 16; k++)
      exp_q.push_back({(k == 15), (k % 4 == 3), f1_data[k]});
  endtask

  // 2x2 frame model: output row R reads input row R/2, column C reads pixel C/2.
  task automatic push_frame(input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3);
    logic [7:0] px [4];
    px[0] = p0; px[1] = p1; px[2] = p2; px[3] = p3;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back({(r == 3 && c == 3), (c == 3), px[(r / 2) * 2 + c / 2]});
  endtask

  task automatic send_pix(input logic [7:0] d);
    logic ok;
    int   n;
    in_data  = d;
    in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("in_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send4(input logic [7:0] p0, input logic [7:0] p1,
                       input logic [7:0] p2, input logic [7:0] p3);
    send_pix(p0); send_pix(p1); send_pix(p2); send_pix(p3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Stall the output for 3 cycles on the first 0x20 (ocnt=2 of row 0).
  task automatic backpressure();
    int  n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      hit = out_valid && (out_data == 8'h20);
    end
    chk("bp_found", 32'(hit), 32'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h20);
      chk("bp_eol", 32'(out_eol), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic monitor();
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rdy_vs_valid", 32'(in_ready), 32'(!out_valid));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", {22'd0, out_eof, out_eol, out_data}, 32'h3ff);
          end else begin
            e = exp_q.pop_front();
            npop++;
            chk("out_beat", {22'd0, out_eof, out_eol, out_data}, {22'd0, e});
          end
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    fork
      monitor();
      begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_eol", 32'(out_eol), 32'd0);
    chk("rst_eof", 32'(out_eof), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame with output stall and held input during replication
    push_f1();
    fork
      begin
        send4(8'h10, 8'h20, 8'h30, 8'h40);
        in_valid = 1'b0;
      end
      backpressure();
    join
    drain();

    // Back-to-back frames with extreme values
    push_frame(8'hFF, 8'h00, 8'h00, 8'hFF);
    push_frame(8'h01, 8'h02, 8'h03, 8'h04);
    send4(8'hFF, 8'h00, 8'h00, 8'hFF);
    send4(8'h01, 8'h02, 8'h03, 8'h04);
    in_valid = 1'b0;
    drain();

    // Reset in the middle of REP0
    out_ready = 1'b0;
    send_pix(8'h10);
    send_pix(8'h20);
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid && n < 20);
    end
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_data", 32'(out_data), 32'h10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_eol", 32'(out_eol), 32'd0);
    chk("mid_rst_eof", 32'(out_eof), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    push_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    send4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    in_valid = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    chk("out_count", 32'(npop), 32'd64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
